// File: rtl/msx_mouse_port.sv
// -----------------------------------------------------------------------------
// msx_mouse_port
//   Converts PS/2 mouse packets (MiSTer 25-bit ps2_mouse bus) into the MSX
//   mouse nibble protocol on one of NPORT joystick ports.
//
//   Motion is summed into saturating signed accumulators. On a qualified
//   strobe rise the accumulators are snapshotted (scaled by SHIFT and
//   clamped to 8 bits) and cleared. The snapshot is then handed out as four
//   nibbles: X high, X low, Y high, Y low. Every strobe edge advances the
//   read by one nibble.
//
//   The strobe is only sampled once every 2^TICK_BITS clocks, which
//   debounces it. A long run of low samples acts as a protocol reset. A read
//   that stalls for TO_TICKS samples is abandoned.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   port_sel   index of the joystick port that carries the mouse
//   strobe     per-port strobe (pin 8)
//   data       per-port {btn2, btn1, d3..d0}; buttons are active-low and
//              unselected ports idle at all-ones
//   ps2_mouse  [24] packet toggle, [23:16] dy, [15:8] dx, [5] dy sign,
//              [4] dx sign, [1:0] right/left buttons
// -----------------------------------------------------------------------------
module msx_mouse_port #(
  parameter int NPORT       = 2,
  parameter int TICK_BITS   = 9,
  parameter int RST_SAMPLES = 8,
  parameter int TO_TICKS    = 64,
  parameter int ACC_W       = 12,
  parameter int SHIFT       = 1,
  localparam int PW         = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PW-1:0]        port_sel,
  input  logic [NPORT-1:0]     strobe,
  output logic [6*NPORT-1:0]   data,
  input  logic [24:0]          ps2_mouse
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XH   = 3'd1,
    S_XL   = 3'd2,
    S_YH   = 3'd3,
    S_YL   = 3'd4
  } state_t;

  // Saturation limits: +/-(2^(ACC_W-1)-1), held two bits wider than the
  // accumulator so that the unclamped sum cannot overflow.
  localparam logic signed [ACC_W+1:0] LIM_P = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] LIM_N = -LIM_P;
  localparam logic signed [ACC_W-1:0] SNAP_HI = {{(ACC_W-7){1'b0}}, 7'h7F};
  localparam logic signed [ACC_W-1:0] SNAP_LO = {{(ACC_W-7){1'b1}}, 7'h00};
  localparam logic [7:0] TO_LAST = 8'(TO_TICKS - 1);

  // Add (or subtract) a 9-bit signed delta, saturating at the limits.
  function automatic logic signed [ACC_W-1:0] sat_acc(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [8:0]       delta,
    input logic                    sub
  );
    logic signed [ACC_W+1:0] a_w;
    logic signed [ACC_W+1:0] d_w;
    logic signed [ACC_W+1:0] sum_w;
    a_w = {{2{acc[ACC_W-1]}}, acc};
    d_w = {{(ACC_W-7){delta[8]}}, delta};
    if (sub) begin
      sum_w = a_w - d_w;
    end else begin
      sum_w = a_w + d_w;
    end
    if (sum_w > LIM_P) begin
      sat_acc = LIM_P[ACC_W-1:0];
    end else if (sum_w < LIM_N) begin
      sat_acc = LIM_N[ACC_W-1:0];
    end else begin
      sat_acc = sum_w[ACC_W-1:0];
    end
  endfunction

  // Scale an accumulator down by SHIFT and clamp it to an 8-bit signed value.
  function automatic logic [7:0] snap8(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SHIFT;
    if (sh > SNAP_HI) begin
      snap8 = 8'h7F;
    end else if (sh < SNAP_LO) begin
      snap8 = 8'h80;
    end else begin
      snap8 = sh[7:0];
    end
  endfunction

  logic [PW-1:0]            sel_r;
  logic                     tog_r;
  logic [TICK_BITS-1:0]     tick_cnt_r;
  logic [RST_SAMPLES-1:0]   hist_r;
  logic [1:0]               btn_r;
  logic [3:0]               nib_r, nib_nx_s;
  logic [7:0]               to_r, to_nx_s;
  logic [3:0]               mx_lo_r;
  logic [7:0]               my_r;
  state_t                   state_r, state_nx_s;
  logic signed [ACC_W-1:0]  acc_x_r, acc_y_r;
  logic signed [ACC_W-1:0]  acc_x_base_s, acc_y_base_s;
  logic signed [ACC_W-1:0]  acc_x_nx_s, acc_y_nx_s;
  logic signed [8:0]        dx_s, dy_s;
  logic [7:0]               snap_x_s, snap_y_s;
  logic                     sel_chg_s, pkt_s, tick_s, strobe_s;
  logic                     proto_rst_s, snap_take_s, moved_s;
  logic                     unused_s;

  assign sel_chg_s   = (port_sel != sel_r);
  assign pkt_s       = ps2_mouse[24] ^ tog_r;
  assign tick_s      = &tick_cnt_r;
  assign dx_s        = {ps2_mouse[4], ps2_mouse[15:8]};
  assign dy_s        = {ps2_mouse[5], ps2_mouse[23:16]};
  assign snap_x_s    = snap8(acc_x_r);
  assign snap_y_s    = snap8(acc_y_r);
  // Protocol reset: the whole history and the current sample are low.
  assign proto_rst_s = (hist_r == {RST_SAMPLES{1'b0}}) && !strobe_s;
  assign unused_s    = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  // Pick the strobe of the selected port; an out-of-range index reads high.
  always_comb begin
    strobe_s = 1'b1;
    for (int p = 0; p < NPORT; p++) begin
      if (sel_r == PW'(p)) begin
        strobe_s = strobe[p];
      end else begin
        strobe_s = strobe_s;
      end
    end
  end

  // Drive the mouse nibble on the selected port and idle-high elsewhere.
  always_comb begin
    data = {(6*NPORT){1'b1}};
    for (int p = 0; p < NPORT; p++) begin
      if (sel_r == PW'(p)) begin
        data[6*p +: 6] = {btn_r, nib_r};
      end else begin
        data[6*p +: 6] = 6'b111111;
      end
    end
  end

  // Next-state logic for the nibble sequencer and the stall timeout.
  always_comb begin
    state_nx_s  = state_r;
    nib_nx_s    = nib_r;
    to_nx_s     = to_r;
    snap_take_s = 1'b0;
    moved_s     = 1'b0;
    if (sel_chg_s) begin
      state_nx_s = S_IDLE;
      nib_nx_s   = 4'h0;
      to_nx_s    = 8'h00;
    end else if (tick_s) begin
      if (proto_rst_s) begin
        state_nx_s = S_IDLE;
        nib_nx_s   = 4'h0;
        to_nx_s    = 8'h00;
      end else begin
        case (state_r)
          S_IDLE: begin
            // Qualified rise: low, then two high samples.
            if (!hist_r[1] && hist_r[0] && strobe_s) begin
              state_nx_s  = S_XH;
              nib_nx_s    = snap_x_s[7:4];
              snap_take_s = 1'b1;
              moved_s     = 1'b1;
            end else begin
              state_nx_s = S_IDLE;
            end
          end
          S_XH: begin
            if (hist_r[0] && !strobe_s) begin
              state_nx_s = S_XL;
              nib_nx_s   = mx_lo_r;
              moved_s    = 1'b1;
            end else begin
              state_nx_s = S_XH;
            end
          end
          S_XL: begin
            if (!hist_r[0] && strobe_s) begin
              state_nx_s = S_YH;
              nib_nx_s   = my_r[7:4];
              moved_s    = 1'b1;
            end else begin
              state_nx_s = S_XL;
            end
          end
          S_YH: begin
            if (hist_r[0] && !strobe_s) begin
              state_nx_s = S_YL;
              nib_nx_s   = my_r[3:0];
              moved_s    = 1'b1;
            end else begin
              state_nx_s = S_YH;
            end
          end
          S_YL: begin
            if (!hist_r[0] && strobe_s) begin
              state_nx_s = S_IDLE;
              nib_nx_s   = 4'h0;
              moved_s    = 1'b1;
            end else begin
              state_nx_s = S_YL;
            end
          end
          default: begin
            state_nx_s = S_IDLE;
            nib_nx_s   = 4'h0;
            moved_s    = 1'b1;
          end
        endcase
        if (moved_s) begin
          to_nx_s = 8'h00;
        end else if (state_r == S_IDLE) begin
          to_nx_s = 8'h00;
        end else if (to_r == TO_LAST) begin
          // Stalled read: abandon it, the accumulators keep new motion.
          state_nx_s = S_IDLE;
          nib_nx_s   = 4'h0;
          to_nx_s    = 8'h00;
        end else begin
          to_nx_s = to_r + 8'd1;
        end
      end
    end else begin
      to_nx_s = to_r;
    end
  end

  // Next accumulator values: a snapshot clears them before the packet lands.
  always_comb begin
    acc_x_base_s = snap_take_s ? {ACC_W{1'b0}} : acc_x_r;
    acc_y_base_s = snap_take_s ? {ACC_W{1'b0}} : acc_y_r;
    if (sel_chg_s) begin
      acc_x_nx_s = {ACC_W{1'b0}};
      acc_y_nx_s = {ACC_W{1'b0}};
    end else if (pkt_s) begin
      acc_x_nx_s = sat_acc(acc_x_base_s, dx_s, 1'b1);
      acc_y_nx_s = sat_acc(acc_y_base_s, dy_s, 1'b0);
    end else begin
      acc_x_nx_s = acc_x_base_s;
      acc_y_nx_s = acc_y_base_s;
    end
  end

  // Sequencer state, output nibble, timeout counter and latched snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      nib_r   <= 4'h0;
      to_r    <= 8'h00;
      mx_lo_r <= 4'h0;
      my_r    <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      nib_r   <= nib_nx_s;
      to_r    <= to_nx_s;
      if (snap_take_s) begin
        mx_lo_r <= snap_x_s[3:0];
        my_r    <= snap_y_s;
      end
    end
  end

  // Motion accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x_r <= {ACC_W{1'b0}};
      acc_y_r <= {ACC_W{1'b0}};
    end else begin
      acc_x_r <= acc_x_nx_s;
      acc_y_r <= acc_y_nx_s;
    end
  end

  // Port select and packet toggle registers, sample tick, strobe history, buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r      <= port_sel;
      tog_r      <= ps2_mouse[24];
      tick_cnt_r <= {TICK_BITS{1'b0}};
      hist_r     <= {RST_SAMPLES{1'b0}};
      btn_r      <= 2'b11;
    end else begin
      sel_r      <= port_sel;
      tog_r      <= ps2_mouse[24];
      tick_cnt_r <= tick_cnt_r + {{(TICK_BITS-1){1'b0}}, 1'b1};
      if (sel_chg_s) begin
        hist_r <= {RST_SAMPLES{1'b0}};
      end else if (tick_s) begin
        hist_r <= {hist_r[RST_SAMPLES-2:0], strobe_s};
      end
      if (sel_chg_s) begin
        btn_r <= 2'b11;
      end else if (pkt_s) begin
        btn_r <= ~ps2_mouse[1:0];
      end
    end
  end

endmodule
